// File: rtl/arp_table_pkg.sv
// Shared types and constants for the ARP IP->MAC resolution table.
package arp_table_pkg;

    localparam int          C_AGE_W     = 8;
    localparam logic [47:0] C_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [31:0]        ip;
        logic [47:0]        mac;
        logic [C_AGE_W-1:0] age;
    } entry_t;

endpackage

// File: rtl/arp_entry_cam.sv
// ARP cache storage: parallel seek/learn compare, free-slot / round-robin victim write,
// and optional per-entry aging when the ARP_AGING_EN macro is defined.
module arp_entry_cam
    import arp_table_pkg::*;
#(
    parameter int          P_ENTRIES   = 8,
    parameter logic [31:0] P_AGE_TICK  = 32'd156_250_000,
    parameter logic [7:0]  P_AGE_LIMIT = 8'd60
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_learn_ip,
    input  logic [47:0] i_learn_mac,
    input  logic        i_learn_valid,
    input  logic [31:0] i_seek_ip,
    input  logic        i_seek_refresh,
    output logic        o_seek_hit,
    output logic [47:0] o_seek_mac,
    output logic [4:0]  o_entry_count
);

    localparam int IDX_W = $clog2(P_ENTRIES);

    entry_t               ent_q [P_ENTRIES];
    entry_t               ent_d [P_ENTRIES];
    logic [IDX_W-1:0]     vic_q, vic_d;
    logic [P_ENTRIES-1:0] seek_m, learn_m;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;

    always_comb begin
        o_seek_hit    = 1'b0;
        o_seek_mac    = '0;
        o_entry_count = '0;
        seek_m        = '0;
        learn_m       = '0;
        for (int i = 0; i < P_ENTRIES; i++) begin
            seek_m[i]  = ent_q[i].valid && (ent_q[i].ip == i_seek_ip);
            learn_m[i] = ent_q[i].valid && (ent_q[i].ip == i_learn_ip);
            if (seek_m[i]) begin
                o_seek_hit = 1'b1;
                o_seek_mac = ent_q[i].mac;
            end
            o_entry_count = o_entry_count + 5'(ent_q[i].valid);
        end
    end

`ifdef ARP_AGING_EN
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic        tick;

    always_comb begin
        tick       = (tick_cnt_q == P_AGE_TICK - 32'd1);
        tick_cnt_d = tick ? 32'd0 : tick_cnt_q + 32'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) tick_cnt_q <= '0;
        else          tick_cnt_q <= tick_cnt_d;
    end
`else
    logic unused_aging;

    always_comb begin
        unused_aging = i_seek_refresh ^ (P_AGE_TICK == 32'd0) ^ (P_AGE_LIMIT == 8'd0);
    end
`endif

    always_comb begin
        ent_d      = ent_q;
        vic_d      = vic_q;
        free_found = 1'b0;
        free_idx   = '0;
`ifdef ARP_AGING_EN
        // Refresh after expiry so an entry hit in its expiry cycle survives.
        for (int i = 0; i < P_ENTRIES; i++) begin
            if (tick && ent_q[i].valid) begin
                if (ent_q[i].age == P_AGE_LIMIT) ent_d[i].valid = 1'b0;
                else                             ent_d[i].age   = ent_q[i].age + 8'd1;
            end
            if (i_seek_refresh && seek_m[i]) begin
                ent_d[i].valid = 1'b1;
                ent_d[i].age   = '0;
            end
        end
`endif
        for (int i = P_ENTRIES - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        if (i_learn_valid) begin
            if (|learn_m) begin
                for (int i = 0; i < P_ENTRIES; i++) begin
                    if (learn_m[i]) begin
                        ent_d[i].valid = 1'b1;
                        ent_d[i].mac   = i_learn_mac;
                        ent_d[i].age   = '0;
                    end
                end
            end else if (free_found) begin
                ent_d[free_idx] = '{valid: 1'b1, ip: i_learn_ip, mac: i_learn_mac, age: '0};
            end else begin
                ent_d[vic_q] = '{valid: 1'b1, ip: i_learn_ip, mac: i_learn_mac, age: '0};
                vic_d        = vic_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < P_ENTRIES; i++) ent_q[i] <= '0;
            vic_q <= '0;
        end else begin
            ent_q <= ent_d;
            vic_q <= vic_d;
        end
    end

endmodule

// File: rtl/arp_ip_mac_table.sv
// IP->MAC resolver: cache lookup, ARP request on miss, wait for learn or timeout.
// Optional entry aging is enabled by defining the ARP_AGING_EN macro.
module arp_ip_mac_table
    import arp_table_pkg::*;
#(
    parameter int          P_ENTRIES     = 8,
    parameter logic [31:0] P_REQ_TIMEOUT = 32'd156_250_000,
    parameter logic [47:0] P_DEFAULT_MAC = C_BCAST_MAC,
    parameter logic [31:0] P_AGE_TICK    = 32'd156_250_000,
    parameter logic [7:0]  P_AGE_LIMIT   = 8'd60
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_seek_ip,
    input  logic        i_seek_ip_valid,
    output logic [47:0] o_seek_mac,
    output logic        o_seek_mac_valid,
    output logic        o_busy,
    input  logic [31:0] i_learn_ip,
    input  logic [47:0] i_learn_mac,
    input  logic        i_learn_valid,
    output logic [31:0] o_arp_req_ip,
    output logic        o_arp_req_valid,
    input  logic        i_arp_req_ready,
    output logic [4:0]  o_entry_count
);

    state_t      state_q, state_d;
    logic [31:0] ip_q, ip_d;
    logic [47:0] mac_q, mac_d;
    logic [31:0] cnt_q, cnt_d;
    logic        cam_hit, learn_hit;
    logic [47:0] cam_mac;

    arp_entry_cam #(
        .P_ENTRIES   (P_ENTRIES),
        .P_AGE_TICK  (P_AGE_TICK),
        .P_AGE_LIMIT (P_AGE_LIMIT)
    ) u_cam (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_learn_ip     (i_learn_ip),
        .i_learn_mac    (i_learn_mac),
        .i_learn_valid  (i_learn_valid),
        .i_seek_ip      (ip_q),
        .i_seek_refresh (state_q == ST_LOOKUP),
        .o_seek_hit     (cam_hit),
        .o_seek_mac     (cam_mac),
        .o_entry_count  (o_entry_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ip_q    <= '0;
            mac_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            mac_q   <= mac_d;
            cnt_q   <= cnt_d;
        end
    end

    // A learn for the pending IP short-circuits the table and the timeout alike.
    always_comb begin
        state_d   = state_q;
        ip_d      = ip_q;
        mac_d     = mac_q;
        cnt_d     = cnt_q;
        learn_hit = i_learn_valid && (i_learn_ip == ip_q);
        case (state_q)
            ST_IDLE: begin
                if (i_seek_ip_valid) begin
                    ip_d    = i_seek_ip;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (cam_hit) begin
                    mac_d   = cam_mac;
                    state_d = ST_RESP;
                end else if (learn_hit) begin
                    mac_d   = i_learn_mac;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (learn_hit) begin
                    mac_d   = i_learn_mac;
                    state_d = ST_RESP;
                end else if (i_arp_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (learn_hit) begin
                    mac_d   = i_learn_mac;
                    state_d = ST_RESP;
                end else if (cnt_d >= P_REQ_TIMEOUT - 32'd1) begin
                    mac_d   = P_DEFAULT_MAC;
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy           = (state_q != ST_IDLE);
        o_seek_mac_valid = (state_q == ST_RESP);
        o_seek_mac       = mac_q;
        o_arp_req_valid  = (state_q == ST_REQ);
        o_arp_req_ip     = ip_q;
    end

endmodule

// File: tb/tb_arp_ip_mac_table.sv
// Directed bench for arp_ip_mac_table: vector table for learn/replace/seek plus
// hand-written sequences for miss, timeout, races and reset (aging when ARP_AGING_EN).
module tb_arp_ip_mac_table;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] seek_ip = '0;
    logic        seek_valid = 1'b0;
    logic [47:0] seek_mac;
    logic        seek_mac_valid;
    logic        busy;
    logic [31:0] learn_ip = '0;
    logic [47:0] learn_mac = '0;
    logic        learn_valid = 1'b0;
    logic [31:0] req_ip;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [4:0]  entry_count;

    int total = 0;
    int bad   = 0;

    arp_ip_mac_table #(
        .P_ENTRIES     (8),
        .P_REQ_TIMEOUT (32'd100),
        .P_DEFAULT_MAC (48'hFFFF_FFFF_FFFF),
        .P_AGE_TICK    (32'd10),
        .P_AGE_LIMIT   (8'd3)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_seek_ip        (seek_ip),
        .i_seek_ip_valid  (seek_valid),
        .o_seek_mac       (seek_mac),
        .o_seek_mac_valid (seek_mac_valid),
        .o_busy           (busy),
        .i_learn_ip       (learn_ip),
        .i_learn_mac      (learn_mac),
        .i_learn_valid    (learn_valid),
        .o_arp_req_ip     (req_ip),
        .o_arp_req_valid  (req_valid),
        .i_arp_req_ready  (req_ready),
        .o_entry_count    (entry_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_seek;
        logic [31:0] ip;
        logic [47:0] mac;
        logic [4:0]  exp_cnt;
        bit          exp_hit;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst count", 64'(entry_count), 64'd0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic learn(input logic [31:0] ip, input logic [47:0] mac);
        learn_ip    = ip;
        learn_mac   = mac;
        learn_valid = 1'b1;
        step();
        learn_valid = 1'b0;
    endtask

    task automatic seek_hit(input string nm, input logic [31:0] ip, input logic [47:0] mac);
        seek_ip    = ip;
        seek_valid = 1'b1;
        step();
        seek_valid = 1'b0;
        chk({nm, " cyc1 valid"}, 64'(seek_mac_valid), 64'd0);
        step();
        chk({nm, " cyc2 valid"}, 64'(seek_mac_valid), 64'd1);
        chk({nm, " mac"}, 64'(seek_mac), 64'(mac));
        chk({nm, " no req"}, 64'(req_valid), 64'd0);
        step();
        chk({nm, " idle"}, 64'(busy), 64'd0);
    endtask

    task automatic seek_miss(input string nm, input logic [31:0] ip);
        seek_ip    = ip;
        seek_valid = 1'b1;
        step();
        seek_valid = 1'b0;
        step();
        chk({nm, " req valid"}, 64'(req_valid), 64'd1);
        chk({nm, " req ip"}, 64'(req_ip), 64'(ip));
        chk({nm, " no resp"}, 64'(seek_mac_valid), 64'd0);
    endtask

    task automatic finish_by_learn(input string nm, input logic [31:0] ip, input logic [47:0] mac);
        learn(ip, mac);
        chk({nm, " resp valid"}, 64'(seek_mac_valid), 64'd1);
        chk({nm, " resp mac"}, 64'(seek_mac), 64'(mac));
        chk({nm, " req dropped"}, 64'(req_valid), 64'd0);
        step();
        chk({nm, " idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        bit saw;

        for (int i = 1; i <= 9; i++)
            vt[i-1] = '{1'b0, 32'hC0A8_0000 + 32'(i), 48'h0200_0000_0000 + 48'(i),
                        (i > 8) ? 5'd8 : 5'(i), 1'b0};
        vt[9]  = '{1'b1, 32'hC0A8_0002, 48'h0200_0000_0002, 5'd8, 1'b1};
        vt[10] = '{1'b1, 32'hC0A8_0009, 48'h0200_0000_0009, 5'd8, 1'b1};
        vt[11] = '{1'b1, 32'hC0A8_0008, 48'h0200_0000_0008, 5'd8, 1'b1};
        vt[12] = '{1'b1, 32'hC0A8_0001, 48'h0A00_0000_0001, 5'd8, 1'b0};
        vt[13] = '{1'b1, 32'hC0A8_0002, 48'h0B00_0000_0002, 5'd8, 1'b0};

        // Reset state
        #2;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset resp valid", 64'(seek_mac_valid), 64'd0);
        chk("reset mac", 64'(seek_mac), 64'd0);
        chk("reset req valid", 64'(req_valid), 64'd0);
        chk("reset req ip", 64'(req_ip), 64'd0);
        chk("reset count", 64'(entry_count), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Cold miss with a stalled request, a dropped seek while busy, then a learn
        seek_miss("cold", 32'hC0A8_6464);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("cold req held", 64'(req_valid), 64'd1);
        end
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk("cold accepted", 64'(req_valid), 64'd0);
        chk("cold waiting", 64'(busy), 64'd1);
        seek_ip    = 32'hC0A8_0077;
        seek_valid = 1'b1;
        step();
        seek_valid = 1'b0;
        chk("busy seek no resp", 64'(seek_mac_valid), 64'd0);
        learn(32'hC0A8_6464, 48'h000A_3501_0203);
        chk("cold resp valid", 64'(seek_mac_valid), 64'd1);
        chk("cold resp mac", 64'(seek_mac), 64'h000A_3501_0203);
        chk("cold count", 64'(entry_count), 64'd1);
        step();
        chk("cold done idle", 64'(busy), 64'd0);
        step();
        chk("dropped seek ignored", 64'(busy), 64'd0);

        seek_hit("hit latency", 32'hC0A8_6464, 48'h000A_3501_0203);

        // Timeout: response 100 cycles after acceptance
        seek_miss("tmo", 32'hC0A8_6401);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        n = 1;
        while (!seek_mac_valid && n < 200) begin
            step();
            n++;
        end
        chk("tmo latency", 64'(n), 64'd100);
        chk("tmo mac", 64'(seek_mac), 64'hFFFF_FFFF_FFFF);
        chk("tmo count", 64'(entry_count), 64'd1);
        step();
        chk("tmo idle", 64'(busy), 64'd0);

        // Learn in the would-be timeout cycle wins
        seek_miss("race tmo", 32'hC0A8_6402);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        repeat (98) step();
        chk("race tmo not yet", 64'(seek_mac_valid), 64'd0);
        finish_by_learn("race tmo", 32'hC0A8_6402, 48'h0000_1111_2222);
        chk("race tmo count", 64'(entry_count), 64'd2);

        // Update and same-cycle learn/seek
        do_reset();
        learn(32'hC0A8_0001, 48'hAAAA_AAAA_AAAA);
        learn(32'hC0A8_0001, 48'hBBBB_BBBB_BBBB);
        chk("update count", 64'(entry_count), 64'd1);
        seek_hit("update", 32'hC0A8_0001, 48'hBBBB_BBBB_BBBB);
        learn_ip    = 32'hC0A8_0005;
        learn_mac   = 48'h0505_0505_0505;
        learn_valid = 1'b1;
        seek_ip     = 32'hC0A8_0005;
        seek_valid  = 1'b1;
        step();
        learn_valid = 1'b0;
        seek_valid  = 1'b0;
        chk("same cyc c1", 64'(seek_mac_valid), 64'd0);
        step();
        chk("same cyc c2 valid", 64'(seek_mac_valid), 64'd1);
        chk("same cyc mac", 64'(seek_mac), 64'h0505_0505_0505);
        chk("same cyc no req", 64'(req_valid), 64'd0);
        step();

        // Replacement table
        do_reset();
        for (int i = 0; i < 14; i++) begin
            if (!vt[i].is_seek) begin
                learn(vt[i].ip, vt[i].mac);
                chk($sformatf("vec%0d count", i), 64'(entry_count), 64'(vt[i].exp_cnt));
            end else if (vt[i].exp_hit) begin
                seek_hit($sformatf("vec%0d", i), vt[i].ip, vt[i].mac);
            end else begin
                seek_miss($sformatf("vec%0d", i), vt[i].ip);
                finish_by_learn($sformatf("vec%0d", i), vt[i].ip, vt[i].mac);
                chk($sformatf("vec%0d count", i), 64'(entry_count), 64'(vt[i].exp_cnt));
            end
        end

        // Reset while waiting drops the request silently
        seek_miss("rst wait", 32'hC0A8_0063);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst wait busy", 64'(busy), 64'd0);
        chk("rst wait req", 64'(req_valid), 64'd0);
        chk("rst wait count", 64'(entry_count), 64'd0);
        step();
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (120) begin
            step();
            if (seek_mac_valid || busy) saw = 1'b1;
        end
        chk("rst wait no resp", 64'(saw), 64'd0);

`ifdef ARP_AGING_EN
        learn(32'hC0A8_0001, 48'h0C0C_0C0C_0C0C);
        chk("age count1", 64'(entry_count), 64'd1);
        repeat (20) step();
        chk("age alive", 64'(entry_count), 64'd1);
        repeat (20) step();
        chk("age expired", 64'(entry_count), 64'd0);
        seek_miss("age", 32'hC0A8_0001);
        finish_by_learn("age", 32'hC0A8_0001, 48'h0D0D_0D0D_0D0D);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
